implication_scheduler: RTL and testbench
========================================

IMPLICATION_SCHEDULER -- requirements
Module: implication_scheduler

Interface
REQ-001 Parameter LIT_W, default 12, width of one implied literal (bit LIT_W-1 = sign, remainder = variable index).
REQ-002 Parameter FIFO_DEPTH, default 4, entries in the output implication FIFO (power of two, >= 2).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 lane_req  input  8  per clause-lane implication request, one-cycle pulse.
REQ-006 lane_lit  input  8*LIT_W  per-lane implied literal; lane i occupies bits [i*LIT_W +: LIT_W].
REQ-007 lane_busy  output  8  pending vector; lane i may pulse lane_req[i] only while lane_busy[i] is 0.
REQ-008 pe_in  output  8  pending snapshot presented to the priority encoder.
REQ-009 pe_request  output  1  encoder hold; 0 = encode pe_in, 1 = idle.
REQ-010 pe_out  input  3  encoder result index.
REQ-011 pe_work  input  1  encoder status; 0 marks the cycle pe_out is valid.
REQ-012 flush  input  1  conflict flush, level-sensitive.
REQ-013 imp_valid  output  1  FIFO head valid.
REQ-014 imp_ready  input  1  downstream accepts head when high with imp_valid.
REQ-015 imp_lit  output  LIT_W  head literal.
REQ-016 imp_lane  output  3  head originating lane.
REQ-017 sched_idle  output  1  no pending lanes, FIFO empty, FSM in IDLE.
REQ-018 pe_err  output  1  sticky: encoder returned a non-pending index.

Function
REQ-019 lane_req[i] with pending[i]=0 SHALL set pending[i] and capture lane_lit slice i on the same edge.
REQ-020 lane_req[i] while pending[i]=1 SHALL be ignored (literal not overwritten).
REQ-021 FSM states: IDLE, ISSUE, RECOVER.
REQ-022 IDLE: pe_request=1; go to ISSUE when pending!=0 and FIFO count plus pending pushes < FIFO_DEPTH; pe_in registered from pending on that transition.
REQ-023 ISSUE: pe_request=0, pe_in held stable; stay until pe_work=0.
REQ-024 On the ISSUE cycle with pe_work=0: capture pe_out; if pending[pe_out]=1, clear it and push {lit[pe_out], pe_out} into FIFO; else set pe_err and push nothing; go to RECOVER.
REQ-025 RECOVER: pe_request=1 for exactly one cycle, then IDLE (allows encoder to re-arm).
REQ-026 Grant order SHALL therefore be highest-index-first; one grant per minimum 3 cycles.
REQ-027 New lane requests arriving during ISSUE SHALL set pending but not alter pe_in.
REQ-028 FIFO: push and pop in same cycle permitted at any count; pop when imp_valid & imp_ready; full SHALL never be overrun (guaranteed by REQ-022).
REQ-029 Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-030 flush=1 SHALL, on the next edge, clear pending, empty FIFO, return FSM to IDLE, discard any in-flight encoder result; lane_req in a flush cycle ignored; pe_err unaffected.
REQ-031 imp_valid, imp_lit, imp_lane SHALL come directly from FIFO registers (no combinational path from lane_req).

Reset
REQ-032 reset SHALL force: pending=0, lane_busy=0, pe_in=0, pe_request=1, FSM=IDLE, FIFO empty, imp_valid=0, imp_lit=0, imp_lane=0, pe_err=0, sched_idle=1.
REQ-033 Reset asserted mid-ISSUE SHALL abandon the grant; no FIFO write on the deasserting edge.

Structure
REQ-034 FSM state encoding and lane count (8) SHALL live in the shared bcp package.
REQ-035 The FIFO SHALL be a sub-module named imp_fifo, parameterised by width LIT_W+3 and FIFO_DEPTH.

Verification
REQ-036 lane_req=8'h24, lit2=12'h805, lit5=12'h013, imp_ready=1 -> imp_lane 5 (lit 12'h013) then 2 (lit 12'h805); lane_busy 8'h24 -> 8'h04 -> 8'h00; sched_idle=1 afterwards.
REQ-037 imp_ready=0, requests on all 8 lanes -> exactly 4 entries pushed (lanes 7,6,5,4), FSM stays IDLE, lane_busy=8'h0F; raise imp_ready -> lanes 3..0 follow.
REQ-038 lane_req[3] pulse twice while busy with different literals -> single FIFO entry carrying first literal.
REQ-039 flush asserted during ISSUE with pending 8'h81 -> next cycle pending=0, FIFO empty, no push, pe_request=1.
REQ-040 Encoder model returns pe_out=1 with pe_in=8'h80 -> pe_err=1 and sticky, no push, pending still 8'h80.
REQ-041 Reset asserted mid-ISSUE with 2 FIFO entries -> all outputs at REQ-032 values asynchronously.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared BCP definitions: lane count, lane index width
// and the implication scheduler FSM state encoding.
package bcp_pkg;

    localparam int NUM_LANES = 8;
    localparam int LANE_W    = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RECOVER
    } sched_state_t;

endpackage

// File: rtl/imp_fifo.sv
// Implication FIFO: registered storage, head read straight from regs.
// Ports: clock/reset, flush (empty), push/din, pop/dout, valid, count.
module imp_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/implication_scheduler.sv
// Implication scheduler: collects per-lane implications, grants them
// through an external priority encoder, queues them into imp_fifo.
// Ports: lane_req/lane_lit/lane_busy (lanes), pe_in/pe_request/
// pe_out/pe_work (encoder), flush, imp_valid/imp_ready/imp_lit/
// imp_lane (output stream), sched_idle, pe_err.
import bcp_pkg::*;

module implication_scheduler #(
    parameter int LIT_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_LANES-1:0]         lane_req,
    input  logic [NUM_LANES*LIT_W-1:0]   lane_lit,
    output logic [NUM_LANES-1:0]         lane_busy,
    output logic [NUM_LANES-1:0]         pe_in,
    output logic                         pe_request,
    input  logic [LANE_W-1:0]            pe_out,
    input  logic                         pe_work,
    input  logic                         flush,
    output logic                         imp_valid,
    input  logic                         imp_ready,
    output logic [LIT_W-1:0]             imp_lit,
    output logic [LANE_W-1:0]            imp_lane,
    output logic                         sched_idle,
    output logic                         pe_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_t          state;
    sched_state_t          state_next;
    logic [NUM_LANES-1:0]  pending;
    logic [LIT_W-1:0]      lit_q [NUM_LANES];
    logic [CW-1:0]         fifo_count;
    logic [LIT_W+2:0]      fifo_head;
    logic                  start;
    logic                  grant_seen;
    logic                  grant_hit;
    logic                  push;

    // In IDLE nothing is in flight, so the count alone bounds room.
    assign start      = (pending != '0) && (fifo_count < CW'(FIFO_DEPTH));
    assign grant_seen = (state == S_ISSUE) && !pe_work;
    assign grant_hit  = grant_seen && pending[pe_out];
    assign push       = grant_hit && !flush;

    assign lane_busy  = pending;
    assign imp_lit    = fifo_head[LIT_W+2:3];
    assign imp_lane   = fifo_head[2:0];
    assign sched_idle = (pending == '0) && !imp_valid
                        && (state == S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pe_request = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                pe_request = 1'b0;
                if (!pe_work) state_next = S_RECOVER;
            end
            S_RECOVER: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lit_q[i] <= '0;
            end
        end else if (flush) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_req[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    lit_q[i]   <= lane_lit[i*LIT_W +: LIT_W];
                end else if (grant_hit && pe_out == LANE_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pe_in  <= '0;
            pe_err <= 1'b0;
        end else begin
            if (state == S_IDLE && start && !flush) begin
                pe_in <= pending;
            end
            if (grant_seen && !pending[pe_out] && !flush) begin
                pe_err <= 1'b1;
            end
        end
    end

    imp_fifo #(
        .W     (LIT_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .din   ({lit_q[pe_out], pe_out}),
        .pop   (imp_ready),
        .dout  (fifo_head),
        .valid (imp_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_implication_scheduler.sv
// Directed bench for implication_scheduler with a behavioural
// priority-encoder model and a pop monitor.
module tb_implication_scheduler;

    logic        clock;
    logic        reset;
    logic [7:0]  lane_req;
    logic [95:0] lane_lit;
    logic [7:0]  lane_busy;
    logic [7:0]  pe_in;
    logic        pe_request;
    logic [2:0]  pe_out;
    logic        pe_work;
    logic        flush;
    logic        imp_valid;
    logic        imp_ready;
    logic [11:0] imp_lit;
    logic [2:0]  imp_lane;
    logic        sched_idle;
    logic        pe_err;

    logic        bad_enc;
    int          vectors;
    int          miscompares;
    logic [2:0]  got_lane [$];
    logic [11:0] got_lit  [$];

    implication_scheduler #(.LIT_W(12), .FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .lane_req   (lane_req),
        .lane_lit   (lane_lit),
        .lane_busy  (lane_busy),
        .pe_in      (pe_in),
        .pe_request (pe_request),
        .pe_out     (pe_out),
        .pe_work    (pe_work),
        .flush      (flush),
        .imp_valid  (imp_valid),
        .imp_ready  (imp_ready),
        .imp_lit    (imp_lit),
        .imp_lane   (imp_lane),
        .sched_idle (sched_idle),
        .pe_err     (pe_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] hi_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Encoder answers in the same cycle it is asked.
    always_comb begin
        pe_work = 1'b1;
        pe_out  = 3'd0;
        if (!pe_request) begin
            pe_work = 1'b0;
            pe_out  = bad_enc ? 3'd1 : hi_idx(pe_in);
        end
    end

    always @(negedge clock) begin
        if (!reset && imp_valid && imp_ready) begin
            got_lane.push_back(imp_lane);
            got_lit.push_back(imp_lit);
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_log();
        got_lane.delete();
        got_lit.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        vectors++;
        if (lane_busy !== 8'h00 || pe_in !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_pend busy=%h pe_in=%h want 00/00",
                     lane_busy, pe_in);
        end
        vectors++;
        if (pe_request !== 1'b1 || sched_idle !== 1'b1 ||
            imp_valid !== 1'b0 || pe_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl req=%b idle=%b v=%b err=%b want 1100",
                     pe_request, sched_idle, imp_valid, pe_err);
        end
        vectors++;
        if (imp_lit !== 12'h000 || imp_lane !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_head lit=%h lane=%0d want 000/0",
                     imp_lit, imp_lane);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_two_lanes();
        clear_log();
        imp_ready = 1'b1;
        lane_lit = '0;
        lane_lit[2*12 +: 12] = 12'h805;
        lane_lit[5*12 +: 12] = 12'h013;
        lane_req = 8'h24;
        tick(1);
        lane_req = 8'h00;
        vectors++;
        if (lane_busy !== 8'h24) begin
            miscompares++;
            $display("FAIL two_busy0 got=%h want=24", lane_busy);
        end
        tick(2);
        vectors++;
        if (lane_busy !== 8'h04 || imp_valid !== 1'b1 ||
            imp_lane !== 3'd5 || imp_lit !== 12'h013) begin
            miscompares++;
            $display("FAIL two_first busy=%h v=%b lane=%0d lit=%h want 04/1/5/013",
                     lane_busy, imp_valid, imp_lane, imp_lit);
        end
        tick(3);
        vectors++;
        if (lane_busy !== 8'h00 || imp_valid !== 1'b1 ||
            imp_lane !== 3'd2 || imp_lit !== 12'h805) begin
            miscompares++;
            $display("FAIL two_second busy=%h v=%b lane=%0d lit=%h want 00/1/2/805",
                     lane_busy, imp_valid, imp_lane, imp_lit);
        end
        tick(1);
        vectors++;
        if (sched_idle !== 1'b1 || imp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL two_idle idle=%b v=%b want 1/0",
                     sched_idle, imp_valid);
        end
        vectors++;
        if (got_lane.size() != 2) begin
            miscompares++;
            $display("FAIL two_count got=%0d want=2", got_lane.size());
        end else if (got_lane[0] !== 3'd5 || got_lane[1] !== 3'd2) begin
            miscompares++;
            $display("FAIL two_order got=%0d,%0d want=5,2",
                     got_lane[0], got_lane[1]);
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        imp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lane_lit[i*12 +: 12] = 12'h100 + 12'(i);
        end
        lane_req = 8'hFF;
        tick(1);
        lane_req = 8'h00;
        tick(20);
        vectors++;
        if (lane_busy !== 8'h0F || pe_request !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold busy=%h req=%b want 0F/1",
                     lane_busy, pe_request);
        end
        vectors++;
        if (imp_valid !== 1'b1 || imp_lane !== 3'd7 ||
            imp_lit !== 12'h107 || sched_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_head v=%b lane=%0d lit=%h idle=%b want 1/7/107/0",
                     imp_valid, imp_lane, imp_lit, sched_idle);
        end
        imp_ready = 1'b1;
        tick(40);
        vectors++;
        if (got_lane.size() != 8) begin
            miscompares++;
            $display("FAIL bp_count got=%0d want=8", got_lane.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got_lane[i] !== 3'(7 - i) ||
                    got_lit[i] !== 12'h100 + 12'(7 - i)) begin
                    miscompares++;
                    $display("FAIL bp_entry%0d lane=%0d lit=%h want %0d/%h",
                             i, got_lane[i], got_lit[i], 7 - i,
                             12'h100 + 12'(7 - i));
                end
            end
        end
        vectors++;
        if (sched_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_idle got=%b want=1", sched_idle);
        end
    endtask

    task automatic test_duplicate();
        clear_log();
        imp_ready = 1'b1;
        lane_lit[3*12 +: 12] = 12'hAAA;
        lane_req = 8'h08;
        tick(1);
        lane_lit[3*12 +: 12] = 12'h555;
        tick(1);
        lane_req = 8'h00;
        tick(10);
        vectors++;
        if (got_lane.size() != 1) begin
            miscompares++;
            $display("FAIL dup_count got=%0d want=1", got_lane.size());
        end else if (got_lane[0] !== 3'd3 || got_lit[0] !== 12'hAAA) begin
            miscompares++;
            $display("FAIL dup_entry lane=%0d lit=%h want 3/AAA",
                     got_lane[0], got_lit[0]);
        end
    endtask

    task automatic test_flush();
        clear_log();
        lane_req = 8'h81;
        tick(1);
        lane_req = 8'h00;
        tick(1);
        vectors++;
        if (pe_request !== 1'b0 || pe_in !== 8'h81) begin
            miscompares++;
            $display("FAIL fl_issue req=%b pe_in=%h want 0/81",
                     pe_request, pe_in);
        end
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        vectors++;
        if (lane_busy !== 8'h00 || imp_valid !== 1'b0 ||
            pe_request !== 1'b1 || sched_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL fl_after busy=%h v=%b req=%b idle=%b want 00/0/1/1",
                     lane_busy, imp_valid, pe_request, sched_idle);
        end
        tick(5);
        vectors++;
        if (got_lane.size() != 0 || pe_err !== 1'b0) begin
            miscompares++;
            $display("FAIL fl_nopush pops=%0d err=%b want 0/0",
                     got_lane.size(), pe_err);
        end
    endtask

    task automatic test_pe_err();
        clear_log();
        bad_enc = 1'b1;
        lane_req = 8'h80;
        tick(1);
        lane_req = 8'h00;
        tick(2);
        vectors++;
        if (pe_err !== 1'b1 || lane_busy !== 8'h80 || imp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL err_set err=%b busy=%h v=%b want 1/80/0",
                     pe_err, lane_busy, imp_valid);
        end
        tick(6);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        bad_enc = 1'b0;
        vectors++;
        if (pe_err !== 1'b1 || lane_busy !== 8'h00 || got_lane.size() != 0) begin
            miscompares++;
            $display("FAIL err_sticky err=%b busy=%h pops=%0d want 1/00/0",
                     pe_err, lane_busy, got_lane.size());
        end
    endtask

    task automatic test_reset_mid_issue();
        imp_ready = 1'b0;
        lane_lit[7*12 +: 12] = 12'h777;
        lane_req = 8'hE0;
        tick(1);
        lane_req = 8'h00;
        tick(7);
        vectors++;
        if (pe_request !== 1'b0 || imp_valid !== 1'b1 || lane_busy !== 8'h20) begin
            miscompares++;
            $display("FAIL rst_pre req=%b v=%b busy=%h want 0/1/20",
                     pe_request, imp_valid, lane_busy);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (lane_busy !== 8'h00 || pe_in !== 8'h00 || pe_request !== 1'b1 ||
            imp_valid !== 1'b0 || imp_lit !== 12'h000 || imp_lane !== 3'd0 ||
            pe_err !== 1'b0 || sched_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async busy=%h pe_in=%h req=%b v=%b lit=%h lane=%0d err=%b idle=%b",
                     lane_busy, pe_in, pe_request, imp_valid, imp_lit,
                     imp_lane, pe_err, sched_idle);
        end
        tick(2);
        reset = 1'b0;
        tick(2);
        vectors++;
        if (imp_valid !== 1'b0 || lane_busy !== 8'h00 || sched_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_release v=%b busy=%h idle=%b want 0/00/1",
                     imp_valid, lane_busy, sched_idle);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        lane_req    = 8'h00;
        lane_lit    = '0;
        flush       = 1'b0;
        imp_ready   = 1'b0;
        bad_enc     = 1'b0;
        test_reset();
        test_two_lanes();
        test_backpressure();
        test_duplicate();
        test_flush();
        test_pe_err();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
